fetch_queue: RTL and testbench

- Parametrised successor to the single-word fetch stage: program-counter generator plus a prefetch instruction queue of QDEPTH entries.
- Issues word reads to an external 1-cycle-latency SRAM and presents instructions to decode over a valid/ready handshake.
- Flushes the queue on branch/jump redirects. Keeps the controller write port used for program loading.

---
 rtl/fetch_queue.sv | 149 ++++++++++++++
 tb/tb_fetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Program-counter generator with a QDEPTH-entry prefetch queue in
//            front of a 1-cycle-latency instruction SRAM; flushes on redirect.
//            Optional macro FETCH_PERF_EN adds pop/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int QDEPTH     = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pc_sel,
    input  logic [ADDR_WIDTH-1:0] imm_addr,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  cntlr_wr,
    input  logic [ADDR_WIDTH-1:0] cntlr_waddr,
    input  logic [DATA_WIDTH-1:0] cntlr_wr_data,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
`ifdef FETCH_PERF_EN
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_flush_cnt
`else
    output logic [DATA_WIDTH-1:0] mem_wr_data
`endif
);

    localparam int              c_idx_w = $clog2(QDEPTH);
    localparam int              c_ptr_w = c_idx_w + 1;
    localparam logic [c_ptr_w:0] c_depth = QDEPTH[c_ptr_w:0];

    logic [ADDR_WIDTH-1:0] r_fpc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_q_data [QDEPTH];
    logic [ADDR_WIDTH-1:0] r_q_pc   [QDEPTH];

    logic [c_ptr_w-1:0]    w_count;
    logic [c_ptr_w:0]      w_occupancy;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [c_idx_w-1:0]    w_head;
    logic [c_idx_w-1:0]    w_tail;

    always_comb begin
        w_count    = r_wr_ptr - r_rd_ptr;
        w_valid    = (w_count != '0);
        w_pop      = w_valid & instr_ready;
        w_redirect = !rst && ((pc_sel == 2'b01) || (pc_sel == 2'b10));
        w_target   = pc_sel[1] ? alu_addr : imm_addr;
        // Credit: queued + outstanding entries after this cycle's pop must leave a free slot.
        w_occupancy = {1'b0, w_count}
                    + {{c_ptr_w{1'b0}}, r_inflight}
                    - {{c_ptr_w{1'b0}}, w_pop};
        w_issue    = !rst && !cntlr_wr && !w_redirect && (w_occupancy < c_depth);
        // A response landing in a redirect cycle belongs to the abandoned path.
        w_push     = r_inflight && !w_redirect;
        w_head     = r_rd_ptr[c_idx_w-1:0];
        w_tail     = r_wr_ptr[c_idx_w-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc         <= ADDR_WIDTH'(RESET_PC);
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (w_redirect) begin
            r_fpc      <= w_target;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fpc         <= r_fpc + 1'b1;
                r_inflight_pc <= r_fpc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Queue storage needs no reset: entries are only visible through a valid count.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_data[w_tail] <= mem_rd_data;
            r_q_pc[w_tail]   <= r_inflight_pc;
        end
    end

    assign instr_valid = w_valid;
    assign instr_data  = w_valid ? r_q_data[w_head] : '0;
    assign instr_pc    = w_valid ? r_q_pc[w_head]   : '0;

    assign mem_rd      = w_issue;
    assign mem_rd_addr = r_fpc;

    assign mem_wr      = cntlr_wr;
    assign mem_wr_addr = cntlr_waddr;
    assign mem_wr_data = cntlr_wr_data;

`ifdef FETCH_PERF_EN
    logic w_discard;

    // Entries surviving this cycle's pop, or an outstanding read, would be lost.
    assign w_discard = (w_count != {{c_idx_w{1'b0}}, w_pop}) || r_inflight;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (w_redirect && w_discard) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed + randomized bench for fetch_queue against a queue-based
//            reference model and a 1-cycle-latency SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int QD  = 4;
    localparam int RPC = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    pc_sel;
    logic [AW-1:0] imm_addr;
    logic [AW-1:0] alu_addr;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          cntlr_wr;
    logic [AW-1:0] cntlr_waddr;
    logic [DW-1:0] cntlr_wr_data;
    logic          mem_rd;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .QDEPTH     (QD),
        .RESET_PC   (RPC)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .pc_sel         (pc_sel),
        .imm_addr       (imm_addr),
        .alu_addr       (alu_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .cntlr_wr       (cntlr_wr),
        .cntlr_waddr    (cntlr_waddr),
        .cntlr_wr_data  (cntlr_wr_data),
        .mem_rd         (mem_rd),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_wr         (mem_wr),
        .mem_wr_addr    (mem_wr_addr),
`ifdef FETCH_PERF_EN
        .mem_wr_data    (mem_wr_data),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`else
        .mem_wr_data    (mem_wr_data)
`endif
    );

    // Instruction SRAM: synchronous write, read data one cycle after mem_rd.
    logic [DW-1:0] sram [1<<AW];
    always @(posedge clk) begin
        if (mem_wr) sram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd) mem_rd_data <= sram[mem_rd_addr];
    end

    // Reference model state
    ent_t          m_q[$];
    ent_t          m_infl_ent;
    bit            m_infl;
    logic [AW-1:0] m_fpc;
    logic [DW-1:0] m_mem [1<<AW];
    bit            m_fresh;
    logic [31:0]   m_pf;
    logic [31:0]   m_pfl;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic t_rst, input logic [1:0] t_sel,
                        input logic [AW-1:0] t_imm, input logic [AW-1:0] t_alu,
                        input logic t_ready, input logic t_wr,
                        input logic [AW-1:0] t_waddr, input logic [DW-1:0] t_wdata);
        bit exp_valid, redir, pop, iss;
        int occ;
        @(negedge clk);
        rst           = t_rst;
        pc_sel        = t_sel;
        imm_addr      = t_imm;
        alu_addr      = t_alu;
        instr_ready   = t_ready;
        cntlr_wr      = t_wr;
        cntlr_waddr   = t_waddr;
        cntlr_wr_data = t_wdata;
        #1;
        exp_valid = (m_q.size() != 0);
        check_eq("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("instr_pc", 32'(instr_pc), 32'(m_q[0].pc));
            check_eq("instr_data", instr_data, m_q[0].data);
        end
        if (m_fresh) begin
            check_eq("rst_instr_pc", 32'(instr_pc), 32'd0);
            check_eq("rst_instr_data", instr_data, 32'd0);
        end
        redir = !t_rst && (t_sel == 2'b01 || t_sel == 2'b10);
        pop   = exp_valid && t_ready;
        occ   = m_q.size() + int'(m_infl) - int'(pop);
        iss   = !t_rst && !t_wr && !redir && (occ < QD);
        check_eq("mem_rd", 32'(mem_rd), 32'(iss));
        if (iss) check_eq("mem_rd_addr", 32'(mem_rd_addr), 32'(m_fpc));
        check_eq("mem_wr", 32'(mem_wr), 32'(t_wr));
        check_eq("mem_wr_addr", 32'(mem_wr_addr), 32'(t_waddr));
        check_eq("mem_wr_data", mem_wr_data, t_wdata);
`ifdef FETCH_PERF_EN
        check_eq("perf_fetch_cnt", perf_fetch_cnt, m_pf);
        check_eq("perf_flush_cnt", perf_flush_cnt, m_pfl);
`endif
        // Advance the model to the state after this cycle's rising edge.
        if (t_wr) m_mem[t_waddr] = t_wdata;
        if (t_rst) begin
            m_q.delete();
            m_infl  = 1'b0;
            m_fpc   = AW'(RPC);
            m_fresh = 1'b1;
            m_pf    = '0;
            m_pfl   = '0;
        end else begin
            m_fresh = 1'b0;
            if (pop) begin
                void'(m_q.pop_front());
                m_pf = m_pf + 32'd1;
            end
            if (redir) begin
                if (m_q.size() != 0 || m_infl) m_pfl = m_pfl + 32'd1;
                m_q.delete();
                m_infl = 1'b0;
                m_fpc  = (t_sel == 2'b01) ? t_imm : t_alu;
            end else begin
                if (m_infl) m_q.push_back(m_infl_ent);
                m_infl = iss;
                if (iss) begin
                    m_infl_ent.pc   = m_fpc;
                    m_infl_ent.data = m_mem[m_fpc];
                    m_fpc           = m_fpc + 1'b1;
                end
            end
        end
    endtask

    task automatic run(input int n, input logic ready);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, ready, 1'b0, '0, '0);
    endtask

    initial begin
        rst           = 1'b1;
        pc_sel        = 2'b00;
        imm_addr      = '0;
        alu_addr      = '0;
        instr_ready   = 1'b0;
        cntlr_wr      = 1'b0;
        cntlr_waddr   = '0;
        cntlr_wr_data = '0;
        m_infl        = 1'b0;
        m_fpc         = AW'(RPC);
        m_fresh       = 1'b1;
        m_pf          = '0;
        m_pfl         = '0;
        repeat (2) @(posedge clk);

        // Program load under reset: word a holds 0x1000_0000 + a.
        for (int a = 0; a < (1 << AW); a++)
            step(1'b1, 2'b00, '0, '0, 1'b0, 1'b1, AW'(a), 32'h1000_0000 + 32'(a));

        run(12, 1'b1);                       // streaming from reset
        run(8, 1'b0);                        // back-pressure fills the queue
        run(6, 1'b1);
        step(1'b0, 2'b01, 11'h040, '0, 1'b1, 1'b0, '0, '0);   // branch redirect
        run(6, 1'b1);
        step(1'b0, 2'b10, '0, 11'h7FF, 1'b1, 1'b0, '0, '0);   // jump to top, wraps
        run(6, 1'b1);
        for (int i = 0; i < 3; i++)          // controller writes mid-stream
            step(1'b0, 2'b00, '0, '0, 1'b1, 1'b1, AW'(11'h300 + i), $urandom);
        run(6, 1'b1);
        step(1'b0, 2'b01, 11'h100, '0, 1'b1, 1'b0, '0, '0);   // back-to-back redirects
        step(1'b0, 2'b10, '0, 11'h200, 1'b1, 1'b0, '0, '0);
        run(4, 1'b1);
        for (int i = 0; i < 4; i++)          // pc_sel=11 is sequential
            step(1'b0, 2'b11, 11'h555, 11'h2AA, 1'b1, 1'b0, '0, '0);
        step(1'b0, 2'b01, 11'h010, '0, 1'b0, 1'b0, '0, '0);
        run(4, 1'b0);
        step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0, '0, '0);        // reset with head at 0x010
        run(6, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            logic          r_rst;
            logic [1:0]    r_sel;
            int            s;
            r_rst = ($urandom_range(0, 199) == 0);
            s     = $urandom_range(0, 31);
            r_sel = (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : (s == 2) ? 2'b11 : 2'b00;
            step(r_rst, r_sel, AW'($urandom), AW'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 AW'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
